counter_display_driver: RTL and testbench

COUNTER_DISPLAY_DRIVER -- requirements
Module: counter_display_driver

---
 rtl/counter_display_driver_pkg.sv | 23 ++
 rtl/bin2bcd_seq.sv | 76 +++++++
 rtl/counter_display_driver.sv | 104 ++++++++++
 tb/tb_counter_display_driver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/counter_display_driver_pkg.sv
// Shared definitions for the counter display driver: converter FSM states
// and the active-low seven-segment patterns.
package counter_display_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // {g,f,e,d,c,b,a}, a zero lights the segment
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    return (digit <= 4'd9) ? SEG_TABLE[digit] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one capture cycle, eight shift cycles
// and one load cycle in which done flags a complete BCD result.
module bin2bcd_seq
  import counter_display_driver_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state, state_next;
  logic [7:0]  shreg;
  logic [11:0] acc;
  logic [11:0] acc_adj;
  logic [2:0]  cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (cnt == 3'd7) state_next = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Every nibble of 5 or more gets +3 before the shift so it carries correctly
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 3; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          shreg <= bin;
          acc   <= '0;
          cnt   <= '0;
        end
        SHIFT: begin
          {acc, shreg} <= {acc_adj, shreg} << 1;
          cnt          <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/counter_display_driver.sv
// Three-digit multiplexed seven-segment driver for an 8-bit count, with
// change-triggered BCD conversion and optional leading-zero blanking.
module counter_display_driver
  import counter_display_driver_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] q_in,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  logic [7:0]  sample;
  logic        first_pending;
  logic        start;
  logic        done;
  logic [11:0] bcd;
  logic [3:0]  dig_h, dig_t, dig_u;
  logic [15:0] scan_cnt;
  logic [1:0]  dig_idx;
  logic        disp_en;
  logic [3:0]  sel_digit;
  logic        blank;
  logic [2:0]  an_sel;

  assign start = !busy && (first_pending || (q_in != sample));

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (q_in),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  // first_pending forces one conversion right after reset even if q_in is 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample        <= '0;
      first_pending <= 1'b1;
    end else if (start) begin
      sample        <= q_in;
      first_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig_h <= '0;
      dig_t <= '0;
      dig_u <= '0;
    end else if (done) begin
      dig_h <= bcd[11:8];
      dig_t <= bcd[7:4];
      dig_u <= bcd[3:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      disp_en  <= 1'b0;
    end else begin
      disp_en <= 1'b1;
      if (scan_cnt == 16'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        dig_idx  <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end
    end
  end

  // Outputs depend only on registers, so q_in never reaches seg/an directly
  always_comb begin
    an_sel    = 3'b110;
    sel_digit = dig_u;
    blank     = 1'b0;
    case (dig_idx)
      2'd1: begin
        an_sel    = 3'b101;
        sel_digit = dig_t;
        blank     = BLANK_LZ && (dig_h == 4'd0) && (dig_t == 4'd0);
      end
      2'd2: begin
        an_sel    = 3'b011;
        sel_digit = dig_h;
        blank     = BLANK_LZ && (dig_h == 4'd0);
      end
      default: ;
    endcase
  end

  assign an  = disp_en ? an_sel : 3'b111;
  assign seg = (!disp_en || blank) ? SEG_BLANK : seg_decode(sel_digit);

endmodule

// File: tb/tb_counter_display_driver.sv
// Directed bench for counter_display_driver with a fast scan (SCAN_DIV=4)
// and leading-zero blanking enabled.
module tb_counter_display_driver;

  logic       clk;
  logic       reset;
  logic [7:0] q_in;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;

  int checkCount = 0;
  int passCount  = 0;

  counter_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .q_in  (q_in),
    .seg   (seg),
    .an    (an),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] value);
    q_in = value;
  endtask

  function automatic logic [6:0] digitPattern(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] expSeg(input logic [2:0] anv, input int val);
    int h, t, u;
    h = val / 100;
    t = (val / 10) % 10;
    u = val % 10;
    case (anv)
      3'b110:  return digitPattern(u);
      3'b101:  return (h == 0 && t == 0) ? 7'h7F : digitPattern(t);
      3'b011:  return (h == 0) ? 7'h7F : digitPattern(h);
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [2:0] nextAn(input logic [2:0] anv);
    case (anv)
      3'b110:  return 3'b101;
      3'b101:  return 3'b011;
      default: return 3'b110;
    endcase
  endfunction

  // Samples n cycles starting now; with n >= 12 all three digits must appear
  task automatic checkDisplay(input int val, input int n, input string tag);
    logic [2:0] seen;
    seen = 3'b000;
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_an_legal"}, 32'(an == 3'b110 || an == 3'b101 || an == 3'b011), 1);
      checkOutput({tag, "_seg"}, seg, expSeg(an, val));
      if (an == 3'b110) seen[0] = 1'b1;
      if (an == 3'b101) seen[1] = 1'b1;
      if (an == 3'b011) seen[2] = 1'b1;
      @(negedge clk);
    end
    if (n >= 12) checkOutput({tag, "_digits_seen"}, seen, 3'b111);
  endtask

  // Called at a negedge; expects capture on the next posedge, 9 busy cycles
  // showing the old value, then the new value displayed
  task automatic runConversion(input bit apply, input int newVal, input int prevVal,
                               input string tag);
    int count;
    if (apply) applyStimulus(8'(newVal));
    @(negedge clk);
    checkOutput({tag, "_busy_rise"}, busy, 1);
    count = 0;
    while (busy && count < 40) begin
      checkOutput({tag, "_hold_old"}, seg, expSeg(an, prevVal));
      count++;
      @(negedge clk);
    end
    checkOutput({tag, "_busy_len"}, count, 9);
    checkDisplay(newVal, 12, tag);
  endtask

  initial begin
    int count, run, changes;
    logic [2:0] prevAn;

    reset = 1'b1;
    applyStimulus(8'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_seg", seg, 7'h7F);
    checkOutput("reset_an", an, 3'b111);
    checkOutput("reset_busy", busy, 0);

    // Boot conversion of 0: only the units digit lit, showing "0"
    reset = 1'b0;
    runConversion(1'b0, 0, 0, "boot");

    runConversion(1'b1, 255, 0, "c255");

    // Scan order and period with the display holding 255
    prevAn  = an;
    run     = 1;
    changes = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checkOutput("scan_an_legal", 32'(an == 3'b110 || an == 3'b101 || an == 3'b011), 1);
      checkOutput("scan_seg", seg, expSeg(an, 255));
      if (an != prevAn) begin
        checkOutput("scan_order", an, nextAn(prevAn));
        if (changes > 0) checkOutput("scan_period", run, 4);
        changes++;
        run    = 1;
        prevAn = an;
      end else begin
        run++;
      end
    end
    checkOutput("scan_changes", 32'(changes >= 6), 1);

    for (int v = 0; v < 256; v++) begin
      runConversion(1'b1, v, (v == 0) ? 255 : v - 1, $sformatf("sweep%0d", v));
    end

    // q_in moves from 100 to 101 during the third shift cycle
    applyStimulus(8'd100);
    @(negedge clk);
    checkOutput("chg_busy_rise", busy, 1);
    count = 0;
    while (busy && count < 40) begin
      if (count == 2) applyStimulus(8'd101);
      count++;
      @(negedge clk);
    end
    checkOutput("chg_busy_len", count, 9);
    checkOutput("chg_first_value", seg, expSeg(an, 100));
    runConversion(1'b0, 101, 100, "chg2");

    // Reset in the middle of converting 200
    applyStimulus(8'd200);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_mid_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_seg", seg, 7'h7F);
    checkOutput("rst_async_an", an, 3'b111);
    checkOutput("rst_async_busy", busy, 0);
    @(negedge clk);
    checkOutput("rst_hold_seg", seg, 7'h7F);
    checkOutput("rst_hold_an", an, 3'b111);
    reset = 1'b0;
    runConversion(1'b0, 200, 0, "rst200");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
